// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared constants and FSM encoding for the 4:1 mux select
// arbiter and its round-robin pick helper.
package mux_arb_pkg;

  localparam int NUM_IN = 4;
  localparam int ADDR_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Index to one-hot grant vector.
  function automatic logic [NUM_IN-1:0] idx2onehot(input logic [ADDR_W-1:0] idx);
    return NUM_IN'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: combinational round-robin search.
// Finds the first set bit of req scanning upward from ptr with wrap.
//   req   : request vector
//   ptr   : highest-priority index for this search
//   found : at least one request set
//   index : winning index (ptr when nothing is found)
module rr_priority_pick
  import mux_arb_pkg::*;
(
  input  logic [NUM_IN-1:0] req,
  input  logic [ADDR_W-1:0] ptr,
  output logic              found,
  output logic [ADDR_W-1:0] index
);

  logic [ADDR_W-1:0] cand;

  // Scan offsets from far to near so the nearest set bit is the last
  // one written and therefore wins.
  always_comb begin
    found = 1'b0;
    index = ptr;
    cand  = ptr;
    for (int k = NUM_IN-1; k >= 0; k--) begin
      cand = ptr + ADDR_W'(k);
      if (req[cand]) begin
        found = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/mux_select_arbiter.sv
// mux_select_arbiter: round-robin arbiter driving the address of a
// downstream 4:1 mux. Two-state FSM (IDLE/GRANT), all outputs registered.
//   clk, rst_n : clock, asynchronous active-low reset
//   req[3:0]   : request lines, bit i selects mux input i
//   done       : current grantee finished (only looked at while valid)
//   address1/0 : registered mux select
//   grant[3:0] : one-hot grant, index == {address1,address0}
//   valid      : a grant is active
//   timeout    : one-cycle pulse after a release forced by HOLD_MAX
module mux_select_arbiter
  import mux_arb_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_IN-1:0] req,
  input  logic              done,
  output logic              address0,
  output logic              address1,
  output logic [NUM_IN-1:0] grant,
  output logic              valid,
  output logic              timeout
);

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        hold_q, hold_d;
  logic [NUM_IN-1:0] grant_q, grant_d;
  logic              valid_q, valid_d;
  logic              timeout_q, timeout_d;

  logic [ADDR_W-1:0] pick_ptr, pick_idx;
  logic              pick_found;
  logic              cur_req, hold_hit, rel;

  // In GRANT the search starts just past the current grantee, so the
  // releasing requester ends up lowest priority for the back-to-back pick.
  assign pick_ptr = (state_q == GRANT) ? addr_q + ADDR_W'(1) : ptr_q;

  rr_priority_pick u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .found (pick_found),
    .index (pick_idx)
  );

  assign cur_req  = req[addr_q];
  assign hold_hit = (hold_q == 8'(HOLD_MAX-1));
  assign rel      = done | ~cur_req | hold_hit;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    addr_d    = addr_q;
    hold_d    = hold_q;
    grant_d   = grant_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = GRANT;
          addr_d  = pick_idx;
          grant_d = idx2onehot(pick_idx);
          valid_d = 1'b1;
          hold_d  = '0;
        end else begin
          // address keeps its last value while idle
          valid_d = 1'b0;
          grant_d = '0;
        end
      end
      GRANT: begin
        if (rel) begin
          ptr_d     = pick_ptr;
          timeout_d = hold_hit & ~done & cur_req;
          if (pick_found) begin
            addr_d  = pick_idx;
            grant_d = idx2onehot(pick_idx);
            valid_d = 1'b1;
            hold_d  = '0;
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
            grant_d = '0;
          end
        end else if (hold_q != 8'hFF) begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      addr_q    <= '0;
      hold_q    <= '0;
      grant_q   <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      addr_q    <= addr_d;
      hold_q    <= hold_d;
      grant_q   <= grant_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign address0 = addr_q[0];
  assign address1 = addr_q[1];
  assign grant    = grant_q;
  assign valid    = valid_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_mux_select_arbiter.sv
// Scoreboard bench: stimulus pushes the model's expected outputs, a
// monitor pops and compares one entry per clock after the rising edge.
module tb_mux_select_arbiter;

  localparam int HM = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = '0;
  logic       done = 1'b0;
  logic       address0, address1, valid, timeout;
  logic [3:0] grant;

  mux_select_arbiter #(.HOLD_MAX(HM)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .done     (done),
    .address0 (address0),
    .address1 (address1),
    .grant    (grant),
    .valid    (valid),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic [3:0] g;
    logic [1:0] a;
    logic       t;
  } exp_t;

  exp_t q[$];
  int   errs = 0;
  int   checks = 0;

  // Reference model: who owns the mux, how long, and where the
  // round-robin search starts next.
  int m_own, m_ptr, m_hold, m_addr;

  function automatic int first_from(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_own = -1; m_ptr = 0; m_hold = 0; m_addr = 0;
  endtask

  task automatic step(input logic [3:0] r, input logic d);
    exp_t e;
    int   nx;
    @(negedge clk);
    req = r; done = d;
    e.t = 1'b0;
    if (m_own < 0) begin
      nx = first_from(r, m_ptr);
      if (nx >= 0) begin m_own = nx; m_hold = 0; m_addr = nx; end
    end else if (d || !r[m_own] || m_hold == HM-1) begin
      e.t   = (m_hold == HM-1) && !d && r[m_own];
      m_ptr = (m_own + 1) % 4;
      nx    = first_from(r, m_ptr);
      if (nx >= 0) begin m_own = nx; m_hold = 0; m_addr = nx; end
      else m_own = -1;
    end else begin
      m_hold++;
    end
    e.v = (m_own >= 0);
    e.g = (m_own >= 0) ? 4'(1 << m_own) : 4'b0;
    e.a = 2'(m_addr);
    q.push_back(e);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; req = '0; done = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: scoreboard compare plus structural and starvation checks.
  exp_t mon_e, mon_got;
  int   wt[4];

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      mon_e   = q.pop_front();
      mon_got = {valid, grant, address1, address0, timeout};
      checks++;
      if (mon_got !== mon_e) begin
        errs++;
        $display("FAIL scoreboard t=%0t got v=%b g=%b a=%b to=%b want v=%b g=%b a=%b to=%b",
                 $time, mon_got.v, mon_got.g, mon_got.a, mon_got.t,
                 mon_e.v, mon_e.g, mon_e.a, mon_e.t);
      end
    end
    if (rst_n) begin
      checks++;
      if (!(grant == 4'b0 && !valid) &&
          !(valid && grant == 4'(1 << {address1, address0}))) begin
        errs++;
        $display("FAIL onehot t=%0t got g=%b a=%b%b v=%b want zero or one-hot matching address",
                 $time, grant, address1, address0, valid);
      end
      checks++;
      for (int i = 0; i < 4; i++) begin
        if (req[i] && !grant[i]) wt[i]++;
        else wt[i] = 0;
        if (wt[i] > 3*HM) begin
          errs++;
          $display("FAIL starve t=%0t req%0d waited %0d want <= %0d", $time, i, wt[i], 3*HM);
          wt[i] = 0;
        end
      end
    end else begin
      for (int i = 0; i < 4; i++) wt[i] = 0;
    end
  end

  logic [3:0] rr;

  initial begin
    model_reset();
    #12;
    checks++;
    if ({valid, grant, address1, address0, timeout} !== 8'b0) begin
      errs++;
      $display("FAIL reset_state got v=%b g=%b a=%b%b to=%b want all zero",
               valid, grant, address1, address0, timeout);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // single request, then done with nothing pending
    step(4'b0100, 1'b0);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b0);

    // full rotation with done every second grant cycle
    apply_reset();
    step(4'b1111, 1'b0);
    repeat (5) begin
      step(4'b1111, 1'b0);
      step(4'b1111, 1'b1);
    end

    // hold limit forces release with timeout
    apply_reset();
    repeat (7) step(4'b0011, 1'b0);
    step(4'b0000, 1'b0);

    // dropping the granted request resumes search after the grantee
    apply_reset();
    step(4'b0010, 1'b0);
    step(4'b1001, 1'b0);
    step(4'b1001, 1'b1);
    step(4'b0000, 1'b1);

    // asynchronous reset in the middle of a grant
    apply_reset();
    step(4'b1000, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({valid, grant, address1, address0, timeout} !== 8'b0) begin
      errs++;
      $display("FAIL async_reset got v=%b g=%b a=%b%b to=%b want all zero",
               valid, grant, address1, address0, timeout);
    end
    model_reset();
    req = '0; done = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b1001, 1'b0);
    step(4'b1001, 1'b1);

    // random traffic with sticky requests
    apply_reset();
    rr = '0;
    repeat (10000) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 7) == 0) rr[i] = ~rr[i];
      step(rr, ($urandom_range(0, 3) == 0));
    end
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b0);
    @(posedge clk);
    #3;
    if (q.size() != 0) begin
      errs++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/mux_select_arbiter.md
MUX_SELECT_ARBITER -- requirements
Module: mux_select_arbiter

Interface
REQ-001 Parameter HOLD_MAX, default 8, is the maximum number of consecutive cycles one grant may be held; the legal range is 2..255.
REQ-002 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n  input  1  is the asynchronous, active-low reset.
REQ-004 Port req  input  4  carries request lines; bit i requests that mux input i be selected.
REQ-005 Port done  input  1  means the current grantee has finished and SHALL be sampled only while valid=1.
REQ-006 Port address0  output  1  is select bit 0 and drives the downstream 4:1 mux address0.
REQ-007 Port address1  output  1  is select bit 1 and drives the downstream 4:1 mux address1.
REQ-008 Port grant  output  4  is a one-hot grant vector whose set bit index equals {address1,address0}.
REQ-009 Port valid  output  1  means a grant is active and the mux output is meaningful.
REQ-010 Port timeout  output  1  is a one-cycle pulse on a forced release at HOLD_MAX.

Function
REQ-011 The block SHALL be a two-state FSM, IDLE and GRANT, with all outputs registered.
REQ-012 In IDLE with req != 0, the block SHALL pick the first set bit searching upward, with wrap, from ptr, and SHALL move to GRANT on the next edge.
- Latency: req sampled at edge n gives valid/grant/address visible after edge n.
REQ-013 In IDLE with req == 0, the block SHALL stay in IDLE with valid=0, grant=0 and the address held at its last value.
REQ-014 In GRANT, address, grant and valid=1 SHALL stay stable until a release condition occurs.
REQ-015 Release conditions are done=1, req[granted]=0, or hold_cnt == HOLD_MAX-1.
REQ-016 On release, ptr SHALL become (granted+1) mod 4.
- The next grant SHALL be chosen in the same cycle from the current req using that new ptr.
- The releasing requester is therefore lowest priority.
REQ-017 On release with other requests pending, the block SHALL grant back-to-back with no idle cycle (valid stays 1).
- If none are pending but the releasing requester still requests, it SHALL be re-granted.
- Otherwise the block SHALL go to IDLE with valid=0.
REQ-018 hold_cnt SHALL be 8 bits, SHALL clear on every new grant, and SHALL increment each GRANT cycle without a release; it SHALL never wrap.
REQ-019 timeout SHALL be 1 for exactly one cycle after a release caused only by hold_cnt, i.e. with done=0 and req[granted]=1.
- If done=1 coincides with the hold limit, timeout SHALL stay 0.
REQ-020 If done=1 and req[granted]=0 occur together, the block SHALL perform a single release.
REQ-021 Changes on req bits other than the granted one SHALL NOT disturb an active grant.
REQ-022 grant SHALL always be zero or one-hot.

Reset
REQ-023 With rst_n=0, the block SHALL asynchronously force state=IDLE, valid=0, grant=0000, address1=0, address0=0, timeout=0, ptr=0 and hold_cnt=0.
REQ-024 Reset mid-grant SHALL drop valid immediately, without waiting for a clock edge.
REQ-025 The first arbitration after reset SHALL give input 0 highest priority.
REQ-026 Reset deassertion SHALL take effect on the first rising clk edge with rst_n=1.

Structure
REQ-027 The shared package mux_arb_pkg SHALL hold the constants NUM_IN=4 and ADDR_W=2 and the FSM state encoding (IDLE, GRANT).
REQ-028 One combinational sub-module, rr_priority_pick, SHALL take (req, ptr) and produce (found, index[1:0]); the top level SHALL own all registers.

Verification
REQ-029 Reset then req=0100 gives valid=1, grant=0100, address1=1, address0=0 one cycle later; done pulse with req=0000 gives valid=0 next cycle.
REQ-030 req=1111 held, done pulsed every 2nd grant cycle, gives the grant order 0001, 0010, 0100, 1000, 0001 with valid never dropping.
REQ-031 HOLD_MAX=4 with req=0011 held and done=0 gives grant 0001 for 4 cycles, then timeout=1 for one cycle with grant=0010.
REQ-032 With grant=0010, dropping req[1] while req=1001 gives the next grant 1000 (ptr=2 search), not 0001.
REQ-033 rst_n=0 asserted between clock edges during grant=1000 gives valid=0, grant=0000 and address=00 immediately; after release, req=1001 grants 0001.
REQ-034 Random req/done over 10k cycles: grant stays zero or one-hot and matches the address; no requester is starved beyond 3*HOLD_MAX cycles.
